jc_decoder: RTL and testbench

JC_DECODER -- requirements
Module: jc_decoder

---
 rtl/jc_decoder.sv | 126 ++++++++++++
 tb/tb_jc_decoder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jc_decoder.sv
// Johnson-code decoder with HUNT/CONFIRM/LOCKED sequence tracking, wrap and error counters.
// Latency: all outputs registered, 1 cycle after a jc_valid sampling edge.
// Backpressure: none; upstream stalls by deasserting jc_valid, which holds all state.
module jc_decoder #(
    parameter int N        = 6,
    parameter int LOCK_CNT = 2,
    localparam int B       = $clog2(2 * N)
) (
    input  logic         clk,
    input  logic         clear,
    input  logic [N-1:0] jc_in,
    input  logic         jc_valid,
    output logic [B-1:0] bin_out,
    output logic         bin_valid,
    output logic         locked,
    output logic         err,
    output logic         wrap,
    output logic [7:0]   wrap_cnt,
    output logic [7:0]   err_cnt
);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t       state, state_nxt;
    logic [N-1:0] prev;
    logic [2:0]   mcnt, mcnt_nxt;
    logic [3:0]   mcnt_inc;
    logic         err_nxt, wrap_nxt;

    logic [N-1:0] inv_in, succ;
    logic         legal, is_succ;
    logic [B-1:0] ones, dec;

    // Legal codes are a run of ones anchored at the LSB, or a run anchored at the MSB.
    assign inv_in  = ~jc_in;
    assign legal   = ((jc_in & (jc_in + N'(1))) == '0) || ((inv_in & (inv_in + N'(1))) == '0);
    assign succ    = {prev[N-2:0], ~prev[N-1]};
    assign is_succ = (jc_in == succ);
    assign mcnt_inc = {1'b0, mcnt} + 4'd1;
    assign locked  = (state == LOCKED);

    always_comb begin
        ones = '0;
        for (int i = 0; i < N; i++) begin
            ones = ones + B'(jc_in[i]);
        end
        dec = jc_in[N-1] ? (B'(2 * N) - ones) : ones;
    end

    always_comb begin
        state_nxt = state;
        mcnt_nxt  = mcnt;
        err_nxt   = 1'b0;
        wrap_nxt  = 1'b0;
        if (jc_valid) begin
            case (state)
                HUNT: begin
                    if (legal) begin
                        state_nxt = CONFIRM;
                        mcnt_nxt  = '0;
                    end
                end
                CONFIRM: begin
                    if (is_succ) begin
                        if (mcnt_inc == 4'(LOCK_CNT)) begin
                            state_nxt = LOCKED;
                            mcnt_nxt  = '0;
                        end else begin
                            mcnt_nxt = mcnt_inc[2:0];
                        end
                    end else if (legal) begin
                        mcnt_nxt = '0;
                    end else begin
                        state_nxt = HUNT;
                    end
                end
                LOCKED: begin
                    // Successor of 2N-1 is the all-zeros code, so this catches exactly the wrap.
                    if (is_succ) begin
                        wrap_nxt = (jc_in == '0);
                    end else begin
                        err_nxt   = 1'b1;
                        mcnt_nxt  = '0;
                        state_nxt = legal ? CONFIRM : HUNT;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= HUNT;
            prev      <= '0;
            mcnt      <= '0;
            bin_out   <= '0;
            bin_valid <= 1'b0;
            err       <= 1'b0;
            wrap      <= 1'b0;
            wrap_cnt  <= '0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            mcnt      <= mcnt_nxt;
            err       <= err_nxt;
            wrap      <= wrap_nxt;
            bin_valid <= jc_valid && legal;
            if (jc_valid && legal) begin
                prev    <= jc_in;
                bin_out <= dec;
            end
            if (wrap_nxt) begin
                wrap_cnt <= wrap_cnt + 8'd1;
            end
            if (err_nxt && (err_cnt != 8'hff)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_jc_decoder.sv
// Directed + lightly randomised bench for jc_decoder; a behavioural model fills a scoreboard queue.
module tb_jc_decoder;
    localparam int N  = 6;
    localparam int LC = 2;
    localparam int B  = 4;

    logic         clk = 1'b0;
    logic         clear;
    logic [N-1:0] jc_in;
    logic         jc_valid;
    logic [B-1:0] bin_out;
    logic         bin_valid, locked, err, wrap;
    logic [7:0]   wrap_cnt, err_cnt;

    jc_decoder #(.N(N), .LOCK_CNT(LC)) dut (
        .clk       (clk),
        .clear     (clear),
        .jc_in     (jc_in),
        .jc_valid  (jc_valid),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .locked    (locked),
        .err       (err),
        .wrap      (wrap),
        .wrap_cnt  (wrap_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] bin, bv, lk, er, wr, wc, ec;
    } exp_t;

    exp_t sb[$];
    int   nvec  = 0;
    int   nfail = 0;

    int         m_state, m_prev, m_mcnt;
    logic [7:0] m_bin, m_wc, m_ec;
    int         cur;

    // Code k built straight from its definition: k LSBs set, or (2N-k) MSBs set.
    function automatic logic [N-1:0] code_of(input int k);
        int m;
        if (k <= N) return N'((1 << k) - 1);
        m = 2 * N - k;
        return N'(((1 << m) - 1) << (N - m));
    endfunction

    function automatic int index_of(input logic [N-1:0] x);
        for (int k = 0; k < 2 * N; k++) begin
            if (code_of(k) == x) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nvec++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic clr, input logic vld, input logic [N-1:0] code);
        exp_t e;
        int   idx;
        logic sc;
        @(negedge clk);
        clear    = clr;
        jc_valid = vld;
        jc_in    = code;
        e   = '0;
        idx = index_of(code);
        if (clr) begin
            m_state = 0; m_prev = 0; m_mcnt = 0;
            m_bin = 8'd0; m_wc = 8'd0; m_ec = 8'd0;
        end else if (vld) begin
            sc = (idx >= 0) && (idx == (m_prev + 1) % (2 * N));
            case (m_state)
                0: if (idx >= 0) begin m_state = 1; m_mcnt = 0; end
                1: begin
                    if (sc) begin
                        m_mcnt++;
                        if (m_mcnt == LC) begin m_state = 2; m_mcnt = 0; end
                    end else if (idx >= 0) begin
                        m_mcnt = 0;
                    end else begin
                        m_state = 0;
                    end
                end
                default: begin
                    if (sc) begin
                        if (idx == 0) begin e.wr = 8'd1; m_wc = m_wc + 8'd1; end
                    end else begin
                        e.er = 8'd1;
                        if (m_ec != 8'd255) m_ec = m_ec + 8'd1;
                        m_state = (idx >= 0) ? 1 : 0;
                        m_mcnt = 0;
                    end
                end
            endcase
            if (idx >= 0) begin
                e.bv   = 8'd1;
                m_prev = idx;
                m_bin  = 8'(idx);
            end
        end
        e.bin = m_bin;
        e.lk  = (m_state == 2) ? 8'd1 : 8'd0;
        e.wc  = m_wc;
        e.ec  = m_ec;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("bin_out",   8'(bin_out),   e.bin);
        chk("bin_valid", 8'(bin_valid), e.bv);
        chk("locked",    8'(locked),    e.lk);
        chk("err",       8'(err),       e.er);
        chk("wrap",      8'(wrap),      e.wr);
        chk("wrap_cnt",  wrap_cnt,      e.wc);
        chk("err_cnt",   err_cnt,       e.ec);
    endtask

    task automatic nxt();
        cur = (cur + 1) % (2 * N);
        drive(1'b0, 1'b1, code_of(cur));
    endtask

    // Repeat the current code while locked, then relock with two successors.
    task automatic force_err();
        drive(1'b0, 1'b1, code_of(cur));
        nxt();
        nxt();
    endtask

    initial begin
        logic [N-1:0] rc;
        int           r, ri;
        clear = 1'b1; jc_valid = 1'b0; jc_in = '0;
        m_state = 0; m_prev = 0; m_mcnt = 0;
        m_bin = 8'd0; m_wc = 8'd0; m_ec = 8'd0;
        cur = 0;

        drive(1'b1, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        chk("reset_locked", 8'(locked), 8'd0);
        chk("reset_bin", 8'(bin_out), 8'd0);

        // Clean acquisition from code 0
        cur = 0;
        drive(1'b0, 1'b1, code_of(0));
        chk("acq_locked0", 8'(locked), 8'd0);
        nxt();
        nxt();
        chk("acq_locked3", 8'(locked), 8'd1);
        nxt();
        chk("acq_bin3", 8'(bin_out), 8'd3);

        // Wrap through 100000 -> 000000
        while (cur != 2 * N - 1) nxt();
        chk("pre_wrap_bin", 8'(bin_out), 8'd11);
        nxt();
        chk("wrap_pulse", 8'(wrap), 8'd1);
        chk("wrap_cnt1", wrap_cnt, 8'd1);
        chk("wrap_bin0", 8'(bin_out), 8'd0);
        nxt();
        chk("wrap_one_cycle", 8'(wrap), 8'd0);

        // Skip 001111: jump from 000111 to 011111
        nxt(); nxt();
        cur = 5;
        drive(1'b0, 1'b1, code_of(cur));
        chk("skip_err", 8'(err), 8'd1);
        chk("skip_err_cnt", err_cnt, 8'd1);
        chk("skip_bin5", 8'(bin_out), 8'd5);

        // Illegal code in CONFIRM, then in LOCKED
        drive(1'b0, 1'b1, 6'b010101);
        chk("ill_hold_bin", 8'(bin_out), 8'd5);
        chk("ill_no_err", 8'(err), 8'd0);
        cur = 8;
        drive(1'b0, 1'b1, code_of(cur));
        nxt(); nxt();
        drive(1'b0, 1'b1, 6'b010101);
        chk("ill_locked_err", 8'(err), 8'd1);

        // Valid gaps along a legal sequence
        cur = 0;
        drive(1'b0, 1'b1, code_of(cur));
        nxt(); nxt(); nxt();
        drive(1'b0, 1'b0, 6'b101010);
        drive(1'b0, 1'b0, 6'b000000);
        chk("gap_hold_bin", 8'(bin_out), 8'd3);
        nxt();
        chk("gap_locked", 8'(locked), 8'd1);

        // Mixed traffic: mostly successors with stalls, repeats, jumps and junk
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
                nxt();
            end else if (r == 6) begin
                drive(1'b0, 1'b0, N'($urandom));
            end else if (r == 7) begin
                rc = N'($urandom);
                ri = index_of(rc);
                if (ri >= 0) cur = ri;
                drive(1'b0, 1'b1, rc);
            end else if (r == 8) begin
                drive(1'b0, 1'b1, code_of(cur));
            end else begin
                cur = int'($urandom_range(0, 2 * N - 1));
                drive(1'b0, 1'b1, code_of(cur));
            end
        end

        // Build wrap_cnt = 3 and err_cnt = 255, then clear while locked
        drive(1'b1, 1'b0, '0);
        cur = 0;
        drive(1'b0, 1'b1, code_of(cur));
        nxt(); nxt();
        repeat (3 * 2 * N) nxt();
        repeat (255) force_err();
        chk("pre_clr_wc", wrap_cnt, 8'd3);
        chk("pre_clr_ec", err_cnt, 8'd255);
        drive(1'b1, 1'b1, code_of((cur + 5) % (2 * N)));
        chk("clr_ec", err_cnt, 8'd0);
        chk("clr_err", 8'(err), 8'd0);

        drive(1'b0, 1'b1, code_of(cur));
        chk("post_clr_err", 8'(err), 8'd0);
        nxt(); nxt();
        repeat (300) force_err();
        chk("sat_ec", err_cnt, 8'd255);

        // 258 wraps while locked: wrap_cnt rolls over to 2
        repeat (258 * 2 * N) nxt();
        chk("rollover_wc", wrap_cnt, 8'd2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
